// File: rtl/bcd_serial_add_ctrl_pkg.sv
// Shared encodings and BCD constants for the serial BCD adder controller
// and its digit cell.
package bcd_serial_add_ctrl_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [3:0] BCD_MAX  = 4'd9;
  localparam logic [4:0] BCD_BASE = 5'd10;
endpackage

// File: rtl/bcd_digit_add.sv
// Single-digit BCD adder cell: a + b + cin, decimal-corrected.
// Invalid input digits still produce a deterministic 4-bit result.
module bcd_digit_add
  import bcd_serial_add_ctrl_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);
  logic [4:0] t;
  logic [4:0] t_adj;

  always_comb begin
    t     = {1'b0, a} + {1'b0, b} + {4'b0, cin};
    t_adj = t - BCD_BASE;
    if (t > {1'b0, BCD_MAX}) begin
      s    = t_adj[3:0];
      cout = 1'b1;
    end else begin
      s    = t[3:0];
      cout = 1'b0;
    end
  end
endmodule

// File: rtl/bcd_serial_add_ctrl.sv
// Serial BCD adder: one shared digit cell walked LSD-first across the
// latched operands, carry rippled through a register, start/busy/done handshake.
module bcd_serial_add_ctrl
  import bcd_serial_add_ctrl_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int IDX_W  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  output logic [4*DIGITS-1:0]   sum,
  output logic                  cout,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);
  state_t              state, state_nxt;
  logic [IDX_W-1:0]    idx;
  logic                carry;
  logic [4*DIGITS-1:0] a_q, b_q;
  logic [3:0]          a_dig, b_dig, s_dig;
  logic                c_dig;
  logic                accept, last;
  logic [DIGITS-1:0]   we;

  assign accept = (state == ST_IDLE) && start;
  assign last   = (idx == IDX_W'(DIGITS - 1));

  // Digit select into the shared cell plus per-digit write enables
  always_comb begin
    a_dig = '0;
    b_dig = '0;
    we    = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        a_dig = a_q[4*i +: 4];
        b_dig = b_q[4*i +: 4];
        we[i] = (state == ST_ADD);
      end
    end
  end

  bcd_digit_add u_cell (
    .a    (a_dig),
    .b    (b_dig),
    .cin  (carry),
    .s    (s_dig),
    .cout (c_dig)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_ADD;
      ST_ADD:  if (last)  state_nxt = ST_DONE;
      ST_DONE:            state_nxt = ST_IDLE;
      default:            state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == ST_ADD);
    done = (state == ST_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      idx   <= '0;
      carry <= 1'b0;
      cout  <= 1'b0;
      err   <= 1'b0;
      sum   <= '0;
    end else if (accept) begin
      a_q   <= a;
      b_q   <= b;
      idx   <= '0;
      carry <= 1'b0;
      err   <= 1'b0;
      sum   <= '0;
    end else if (state == ST_ADD) begin
      carry <= c_dig;
      err   <= err | (a_dig > BCD_MAX) | (b_dig > BCD_MAX);
      if (last) cout <= c_dig;
      else      idx  <= idx + 1'b1;
      for (int i = 0; i < DIGITS; i++)
        if (we[i]) sum[4*i +: 4] <= s_dig;
    end
  end
endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Scoreboard bench for bcd_serial_add_ctrl: expected results queued at issue,
// popped and checked by a monitor on every done pulse.
module tb_bcd_serial_add_ctrl;
  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [W-1:0] sum;
  logic         cout, busy, done, err;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         err;
    int           issue;
  } exp_t;

  exp_t q[$];
  exp_t e_mon;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   busy_cnt = 0;

  bcd_serial_add_ctrl #(.DIGITS(DIGITS), .IDX_W(3)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .sum   (sum),
    .cout  (cout),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Reference: decimal digit-by-digit addition with carry, flagging digits > 9
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input int issue);
    exp_t m;
    int c = 0;
    m.sum = '0;
    m.err = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      int da = int'(x[4*i +: 4]);
      int db = int'(y[4*i +: 4]);
      int t  = da + db + c;
      if (t > 9) begin t = t - 10; c = 1; end
      else c = 0;
      m.sum[4*i +: 4] = 4'(t);
      if (da > 9 || db > 9) m.err = 1'b1;
    end
    m.cout  = (c != 0);
    m.issue = issue;
    return m;
  endfunction

  function automatic logic [W-1:0] rand_op();
    logic [W-1:0] v = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if ($urandom_range(0, 7) == 0) v[4*i +: 4] = 4'($urandom_range(10, 15));
      else                           v[4*i +: 4] = 4'($urandom_range(0, 9));
    end
    return v;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst) busy_cnt = 0;
    else begin
      if (busy) busy_cnt++;
      if (done) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_done: got done=1 want no pulse (t=%0t)", $time);
        end else begin
          e_mon = q.pop_front();
          chk("sum", sum, e_mon.sum);
          chk("cout", W'(cout), W'(e_mon.cout));
          chk("err", W'(err), W'(e_mon.err));
          chk("latency", W'(cyc - e_mon.issue), W'(DIGITS));
          chk("busy_cycles", W'(busy_cnt), W'(DIGITS));
        end
        busy_cnt = 0;
      end
    end
  end

  // Called at a negedge; start is sampled on the following edge
  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y);
    a = x;
    b = y;
    start = 1'b1;
    q.push_back(model(x, y, cyc + 1));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_drain();
    int k = 0;
    while (q.size() != 0 && k < 60) begin
      @(negedge clk);
      k++;
    end
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d pending want 0", q.size());
      q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_sum", sum, '0);
    chk("rst_cout", W'(cout), '0);
    chk("rst_busy", W'(busy), '0);
    chk("rst_done", W'(done), '0);
    chk("rst_err", W'(err), '0);
    rst = 1'b0;
    @(negedge clk);

    issue(16'h1234, 16'h5678);
    wait_drain();
    issue(16'h9999, 16'h0001);
    wait_drain();

    // Abort mid-operation: outputs clear asynchronously, no done afterwards
    issue(16'h1234, 16'h5678);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_sum", sum, '0);
    chk("abort_cout", W'(cout), '0);
    chk("abort_busy", W'(busy), '0);
    chk("abort_done", W'(done), '0);
    chk("abort_err", W'(err), '0);
    q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);

    // Start held high for 10 edges: accepted at N and N+6 only
    a = '0;
    b = '0;
    start = 1'b1;
    q.push_back(model('0, '0, cyc + 1));
    q.push_back(model('0, '0, cyc + 7));
    repeat (10) @(negedge clk);
    start = 1'b0;
    wait_drain();

    issue(16'h00A0, 16'h0000);
    wait_drain();
    issue(16'h0001, 16'h0001);
    wait_drain();

    // Start and operand changes during an operation are ignored
    issue(16'h4321, 16'h0789);
    @(negedge clk);
    start = 1'b1;
    a = 16'h9999;
    b = 16'h9999;
    @(negedge clk);
    start = 1'b0;
    a = 16'h5555;
    wait_drain();

    for (int n = 0; n < 40; n++) begin
      issue(rand_op(), rand_op());
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        a = rand_op();
        b = rand_op();
      end
      wait_drain();
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
